// File: rtl/stage_mem_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: access encodings,
// FSM state encoding and lane count.
package stage_mem_lsu_pkg;

   localparam int LSU_LANES = 4;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/stage_mem_lsu_if.sv
// Data-memory port: req/gnt request phase followed by an rvalid response
// phase for reads.
interface stage_mem_lsu_if
   import stage_mem_lsu_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic                 req;
   logic                 we;
   logic [WIDTH-1:0]     addr;
   logic [LSU_LANES-1:0] be;
   logic [WIDTH-1:0]     wdata;
   logic                 gnt;
   logic                 rvalid;
   logic [WIDTH-1:0]     rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/stage_mem_lsu_align.sv
// Byte-lane helper: legality/alignment of the request, store byte enables and
// lane replication, and load extraction with sign/zero extension.
module stage_mem_lsu_align
   import stage_mem_lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 rd,
   input  logic                 wr,
   input  logic [2:0]           funct3,
   input  logic [1:0]           off,
   input  logic [WIDTH-1:0]     wdata,
   output logic [LSU_LANES-1:0] be,
   output logic [WIDTH-1:0]     wdata_rep,
   output logic                 legal,
   output logic                 aligned,
   input  logic [2:0]           rsp_funct3,
   input  logic [1:0]           rsp_off,
   input  logic [WIDTH-1:0]     rdata,
   output logic [WIDTH-1:0]     load_data
);

   function automatic logic [WIDTH-1:0] ext8(input logic [7:0] b, input logic sgn);
      return {{(WIDTH-8){sgn & b[7]}}, b};
   endfunction

   function automatic logic [WIDTH-1:0] ext16(input logic [15:0] h, input logic sgn);
      return {{(WIDTH-16){sgn & h[15]}}, h};
   endfunction

   logic [WIDTH-1:0] shifted;

   always_comb begin
      legal = 1'b0;
      if (rd && !wr)
         legal = funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
      else if (wr && !rd)
         legal = funct3 inside {LSU_B, LSU_H, LSU_W};

      // funct3[1:0] encodes the access size for both signed and unsigned forms
      aligned = 1'b1;
      case (funct3[1:0])
         2'b01:   aligned = ~off[0];
         2'b10:   aligned = (off == 2'b00);
         default: aligned = 1'b1;
      endcase

      be        = 4'b1111;
      wdata_rep = wdata;
      case (funct3[1:0])
         2'b00: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << off;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = rdata >> {rsp_off, 3'b000};
      case (rsp_funct3)
         LSU_B:   load_data = ext8(shifted[7:0], 1'b1);
         LSU_H:   load_data = ext16(shifted[15:0], 1'b1);
         LSU_BU:  load_data = ext8(shifted[7:0], 1'b0);
         LSU_HU:  load_data = ext16(shifted[15:0], 1'b0);
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid access per
// instruction, stalls the pipeline while it is outstanding, and flags bad accesses.
module stage_mem_lsu
   import stage_mem_lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid_MEM,
   input  logic             i_mem_read_MEM,
   input  logic             i_mem_write_MEM,
   input  logic [2:0]       i_funct3_MEM,
   input  logic [WIDTH-1:0] i_alu_result_MEM,
   input  logic [WIDTH-1:0] i_write_data_MEM,
   stage_mem_lsu_if.master  dmem,
   output logic [WIDTH-1:0] o_read_data_MEM,
   output logic             o_done_MEM,
   output logic             o_stall_MEM,
   output logic             o_err_MEM
);

   lsu_state_t state_q, state_d;

   logic [WIDTH-1:0]     addr_q;
   logic [WIDTH-1:0]     wdata_q;
   logic [WIDTH-1:0]     rdata_q;
   logic [LSU_LANES-1:0] be_q;
   logic                 we_q;
   logic [2:0]           funct3_q;
   logic [1:0]           off_q;

   logic [LSU_LANES-1:0] be_c;
   logic [WIDTH-1:0]     wdata_c;
   logic [WIDTH-1:0]     load_c;
   logic                 legal_c;
   logic                 aligned_c;
   logic                 access_c;
   logic                 start;
   logic                 capture;
   logic                 err;

   stage_mem_lsu_align #(.WIDTH(WIDTH)) u_align (
      .rd         (i_mem_read_MEM),
      .wr         (i_mem_write_MEM),
      .funct3     (i_funct3_MEM),
      .off        (i_alu_result_MEM[1:0]),
      .wdata      (i_write_data_MEM),
      .be         (be_c),
      .wdata_rep  (wdata_c),
      .legal      (legal_c),
      .aligned    (aligned_c),
      .rsp_funct3 (funct3_q),
      .rsp_off    (off_q),
      .rdata      (dmem.rdata),
      .load_data  (load_c)
   );

   assign access_c = i_valid_MEM & (i_mem_read_MEM | i_mem_write_MEM);

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      capture = 1'b0;
      err     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_c && legal_c && aligned_c) begin
               start   = 1'b1;
               state_d = ST_REQ;
            end else if (access_c) begin
               err = 1'b1;
            end
         end
         ST_REQ: begin
            if (dmem.gnt)
               state_d = we_q ? ST_DONE : ST_RESP;
         end
         ST_RESP: begin
            // rvalid is only meaningful here; a same-cycle rvalid with gnt is dropped
            if (dmem.rvalid) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         off_q    <= '0;
         rdata_q  <= '0;
      end else begin
         if (start) begin
            addr_q   <= {i_alu_result_MEM[WIDTH-1:2], 2'b00};
            wdata_q  <= wdata_c;
            be_q     <= be_c;
            we_q     <= i_mem_write_MEM;
            funct3_q <= i_funct3_MEM;
            off_q    <= i_alu_result_MEM[1:0];
         end
         if (capture)
            rdata_q <= load_c;
      end
   end

   assign dmem.req        = (state_q == ST_REQ);
   assign dmem.we         = dmem.req & we_q;
   assign dmem.addr       = addr_q;
   assign dmem.be         = be_q;
   assign dmem.wdata      = wdata_q;

   assign o_read_data_MEM = rdata_q;
   assign o_done_MEM      = (state_q == ST_DONE);
   assign o_err_MEM       = err;
   assign o_stall_MEM     = start | (state_q == ST_REQ) | (state_q == ST_RESP);

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: directed and randomized loads/stores against an
// arithmetic reference model of lane selection and extension.
module tb_stage_mem_lsu;
   import stage_mem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        valid = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [2:0]  f3 = 3'b000;
   logic [31:0] alu = '0, wd = '0;
   logic [31:0] rdata_out;
   logic        done, stall, err;

   int passed = 0;
   int total  = 0;
   logic [31:0] last_load = '0;

   always #5 clk = ~clk;

   stage_mem_lsu_if #(.WIDTH(32)) bus ();

   stage_mem_lsu #(.WIDTH(32)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_valid_MEM      (valid),
      .i_mem_read_MEM   (rd),
      .i_mem_write_MEM  (wr),
      .i_funct3_MEM     (f3),
      .i_alu_result_MEM (alu),
      .i_write_data_MEM (wd),
      .dmem             (bus),
      .o_read_data_MEM  (rdata_out),
      .o_done_MEM       (done),
      .o_stall_MEM      (stall),
      .o_err_MEM        (err)
   );

   function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v;
      v = w >> (8 * (a % 4));
      case (f)
         3'b000: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
         3'b001: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
         3'b100: v = v % 256;
         3'b101: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
      int unsigned n;
      n = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 3 : 15;
      return 4'((n << (a % 4)) % 16);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
      if (f == 3'b000) return (d % 256) * 32'h0101_0101;
      if (f == 3'b001) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic bit exp_ok(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
      bit lg;
      if (r == w) return 1'b0;
      lg = r ? (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) : (f <= 2);
      if (!lg) return 1'b0;
      if (f % 4 == 1) return (a % 2 == 0);
      if (f % 4 == 2) return (a % 4 == 0);
      return 1'b1;
   endfunction

   task automatic do_access(input logic is_ld, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] word,
                            input int gd, input int rvd, input bit spur);
      @(negedge clk);
      valid = 1'b1; rd = is_ld; wr = !is_ld; f3 = f; alu = a; wd = d;
      #1;
      total++;
      if ({stall, err, bus.req} !== 3'b100) $display("FAIL accept: stall/err/req=%b want 100", {stall, err, bus.req});
      else passed++;
      @(negedge clk);
      valid = 1'b0; rd = 1'b0; wr = 1'b0;
      for (int i = 0; i <= gd; i++) begin
         if (i > 0) @(negedge clk);
         if (spur) begin bus.rvalid = 1'b1; bus.rdata = $urandom; end
         if (i == gd) bus.gnt = 1'b1;
         #1;
         total++;
         if ({bus.req, stall, bus.we} !== {2'b11, !is_ld})
            $display("FAIL req_phase: req/stall/we=%b want %b", {bus.req, stall, bus.we}, {2'b11, !is_ld});
         else passed++;
         total++;
         if ({bus.addr, bus.be} !== {a - (a % 4), exp_be(f, a)})
            $display("FAIL req_addr_be: got %h/%b want %h/%b", bus.addr, bus.be, a - (a % 4), exp_be(f, a));
         else passed++;
         if (!is_ld) begin
            total++;
            if (bus.wdata !== exp_wdata(f, d)) $display("FAIL wdata: got %h want %h", bus.wdata, exp_wdata(f, d));
            else passed++;
         end
      end
      @(negedge clk);
      bus.gnt = 1'b0; bus.rvalid = 1'b0;
      if (is_ld) begin
         for (int j = 0; j <= rvd; j++) begin
            if (j > 0) @(negedge clk);
            if (j == rvd) begin bus.rvalid = 1'b1; bus.rdata = word; end
            #1;
            total++;
            if ({bus.req, stall, done} !== 3'b010) $display("FAIL resp_wait: req/stall/done=%b want 010", {bus.req, stall, done});
            else passed++;
         end
         @(negedge clk);
         bus.rvalid = 1'b0;
         last_load = exp_load(f, a, word);
      end
      #1;
      total++;
      if ({done, stall, bus.req} !== 3'b100) $display("FAIL done_cycle: done/stall/req=%b want 100", {done, stall, bus.req});
      else passed++;
      total++;
      if (rdata_out !== last_load) $display("FAIL read_data: got %h want %h", rdata_out, last_load);
      else passed++;
      @(negedge clk);
      #1;
      total++;
      if ({done, stall} !== 2'b00) $display("FAIL done_pulse: done/stall=%b want 00", {done, stall});
      else passed++;
   endtask

   task automatic do_bad(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
      @(negedge clk);
      valid = 1'b1; rd = r; wr = w; f3 = f; alu = a; wd = $urandom;
      #1;
      total++;
      if ({err, stall, bus.req} !== {(r | w), 2'b00})
         $display("FAIL bad_access: err/stall/req=%b want %b", {err, stall, bus.req}, {(r | w), 2'b00});
      else passed++;
      @(negedge clk);
      valid = 1'b0; rd = 1'b0; wr = 1'b0;
      #1;
      total++;
      if ({err, stall, bus.req, done} !== 4'b0000) $display("FAIL bad_after: err/stall/req/done=%b want 0000", {err, stall, bus.req, done});
      else passed++;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus.req, bus.we, done, err, stall} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {bus.req, bus.we, done, err, stall});
      else passed++;
      total++;
      if ({bus.addr, bus.be, bus.wdata, rdata_out} !== '0)
         $display("FAIL reset_data: addr %h be %b wdata %h rd %h want all 0", bus.addr, bus.be, bus.wdata, rdata_out);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      do_access(1'b0, LSU_W,  32'h100, 32'hDEAD_BEEF, '0, 2, 0, 1'b0);
      do_access(1'b0, LSU_B,  32'h103, 32'h0000_00A5, '0, 0, 0, 1'b0);
      do_access(1'b1, LSU_B,  32'h101, '0, 32'h0000_8000, 0, 0, 1'b0);
      do_access(1'b1, LSU_BU, 32'h101, '0, 32'h0000_8000, 0, 0, 1'b0);
      do_access(1'b1, LSU_H,  32'h102, '0, 32'h8001_0000, 0, 0, 1'b0);
      do_access(1'b0, LSU_H,  32'h106, 32'h1234_C3D2, '0, 1, 0, 1'b0);
   endtask

   task automatic test_errors();
      do_bad(1'b1, 1'b0, LSU_W, 32'h102);
      do_bad(1'b1, 1'b0, 3'b011, 32'h100);
      do_bad(1'b0, 1'b1, LSU_BU, 32'h100);
      do_bad(1'b1, 1'b1, LSU_W, 32'h100);
      do_bad(1'b0, 1'b1, LSU_H, 32'h101);
      do_bad(1'b0, 1'b0, LSU_W, 32'h100);
   endtask

   task automatic test_spurious_rvalid();
      do_access(1'b1, LSU_W, 32'h200, '0, 32'h0BAD_F00D, 1, 3, 1'b1);
      do_access(1'b1, LSU_HU, 32'h20A, '0, 32'hFACE_0000, 0, 2, 1'b1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      valid = 1'b1; rd = 1'b1; wr = 1'b0; f3 = LSU_W; alu = 32'h300;
      @(negedge clk);
      valid = 1'b0; rd = 1'b0; bus.gnt = 1'b1;
      @(negedge clk);
      bus.gnt = 1'b0;
      #1;
      total++;
      if ({bus.req, stall} !== 2'b01) $display("FAIL mid_resp: req/stall=%b want 01", {bus.req, stall});
      else passed++;
      rst_n = 1'b0;
      #1;
      last_load = '0;
      total++;
      if ({bus.req, stall, done, rdata_out} !== {3'b000, last_load})
         $display("FAIL mid_reset: req/stall/done=%b rd=%h want 000/%h", {bus.req, stall, done}, rdata_out, last_load);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      bus.rvalid = 1'b1; bus.gnt = 1'b1; bus.rdata = 32'h5555_AAAA;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         total++;
         if ({done, stall, bus.req} !== 3'b000) $display("FAIL late_resp: done/stall/req=%b want 000", {done, stall, bus.req});
         else passed++;
      end
      bus.rvalid = 1'b0; bus.gnt = 1'b0;
      total++;
      if (rdata_out !== last_load) $display("FAIL late_data: got %h want %h", rdata_out, last_load);
      else passed++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic r, w;
         logic [2:0] f;
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         r = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         w = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !r;
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         if (exp_ok(r, w, f, a))
            do_access(r, f, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         else
            do_bad(r, w, f, a);
      end
   endtask

   initial begin
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      test_reset();
      test_directed();
      test_errors();
      test_spurious_rvalid();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/stage_mem_lsu.md
# stage_mem_lsu

Memory-stage load/store unit for the OSIRIS I pipeline; consumes the execute-stage ALU result as the effective address plus the rs2 store data and funct3. Drives a req/gnt/rvalid data-memory port with byte enables and stalls the pipeline for the whole access. Returns sign- or zero-extended load data to writeback. Misaligned or illegal accesses are flagged and never reach memory.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (4 byte lanes)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset; single clock domain, async assert
- i_valid_MEM  in  1  instruction in MEM stage is valid
- i_mem_read_MEM  in  1  load instruction
- i_mem_write_MEM  in  1  store instruction
- i_funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_alu_result_MEM  in  WIDTH  effective byte address from ALU
- i_write_data_MEM  in  WIDTH  rs2 store data
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  WIDTH  word address, bits [1:0] forced 0
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  WIDTH  lane-replicated store data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  WIDTH  read word
- o_read_data_MEM  out  WIDTH  extended load result
- o_done_MEM  out  1  one-cycle pulse: access complete
- o_stall_MEM  out  1  hold IF/ID/EX/MEM stages
- o_err_MEM  out  1  one-cycle pulse: misaligned or illegal access

## Operation
- States: IDLE, REQ, RESP, DONE.
- Start = i_valid_MEM & (read ^ write) & legal & aligned, evaluated in IDLE only.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else, or read & write both high, is illegal.
- Aligned: H needs addr[0]=0; W needs addr[1:0]=00; B always aligned.
- IDLE: on start, register addr/be/wdata/we/funct3/offset, go REQ. On valid access that is illegal or misaligned: o_err_MEM=1 that cycle, stay IDLE, no req, no stall.
- REQ: o_dmem_req=1, address/be/we/wdata held stable from registers until i_dmem_gnt. Gnt with store -> DONE; gnt with load -> RESP.
- RESP: wait for i_dmem_rvalid (same-cycle rvalid with gnt is not accepted; rvalid is only sampled in RESP). On rvalid capture extended data into o_read_data_MEM register, go DONE.
- DONE: o_done_MEM=1, o_stall_MEM=0, go IDLE (a new access can start next cycle).
- Store formatting: SB wdata = {4{byte}}, be = 0001<<addr[1:0]; SH wdata = {2{half}}, be = 0011<<addr[1:0]; SW be = 1111.
- Load extraction: shift rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through.
- o_read_data_MEM holds last load value until next load completes; unchanged by stores.
- gnt in IDLE/RESP/DONE and rvalid outside RESP are ignored.

## Timing
- Reset values: state IDLE; o_dmem_req, o_dmem_we, o_done_MEM, o_err_MEM, o_stall_MEM = 0; o_dmem_addr, o_dmem_be, o_dmem_wdata, o_read_data_MEM = 0.
- o_stall_MEM = (IDLE & start) | REQ | RESP; combinational, asserted in the accept cycle.
- Minimum latency (gnt first REQ cycle, rvalid first RESP cycle): load accept T0, req T1, rvalid T2, done+data T3; store accept T0, req T1, done T2.
- Reset mid-access: req drops asynchronously, return to IDLE; late rvalid/gnt ignored.
- No timeout; REQ/RESP wait indefinitely.

## Structure
- osiris_pkg: funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state encoding, lane count.
- Sub-module lsu_align (combinational): computes be, replicated wdata, aligned/legal flags, and load extraction/extension; top holds FSM and registers.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> addr 0x100, be 1111, req held 3 cycles, done at T4, stall T0–T3.
- SB addr 0x103, data 0x000000A5 -> addr 0x100, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x101, rdata 0x0000_80_00 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102, rdata 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x102 -> o_err_MEM pulse, no req, no stall; funct3 011 load -> same.
- Load, rvalid delayed 3 cycles with spurious rvalid in REQ -> spurious ignored, data from RESP rvalid only.
- Assert i_rst_n low during RESP -> req/stall 0 immediately, state IDLE, later rvalid produces no done.
